// File: rtl/zorro_master_cycle_pkg.sv
// Shared types and constants for the Zorro III bus-master cycle sequencer.
package zorro_master_cycle_pkg;

  localparam int ZM_LANES = 4;
  localparam int ZM_SIZ_W = 2;
  localparam int ZM_A_W   = 2;

  localparam logic [ZM_SIZ_W-1:0] SIZ_LONG  = 2'b00;
  localparam logic [ZM_SIZ_W-1:0] SIZ_BYTE  = 2'b01;
  localparam logic [ZM_SIZ_W-1:0] SIZ_WORD  = 2'b10;
  localparam logic [ZM_SIZ_W-1:0] SIZ_3BYTE = 2'b11;

  typedef enum logic [2:0] {
    ZM_IDLE,
    ZM_ADDR,
    ZM_DATA,
    ZM_TERM,
    ZM_ERR,
    ZM_RECOVER
  } zm_state_t;

endpackage

// File: rtl/zorro_master_cycle_if.sv
// NCR-side request and Zorro-side strobe signals of one bus-master cycle.
interface zorro_master_cycle_if;
  import zorro_master_cycle_pkg::*;

  logic                req;
  logic                req_read;
  logic [ZM_SIZ_W-1:0] req_siz;
  logic [ZM_A_W-1:0]   req_a;
  logic                bmaster;
  logic                dtack;
  logic                berr;
  logic                fcs;
  logic [ZM_LANES-1:0] ds;
  logic                doe;
  logic                read_out;
  logic                ack;
  logic                err;
  logic                busy;

  modport master (
    input  req, req_read, req_siz, req_a, bmaster, dtack, berr,
    output fcs, ds, doe, read_out, ack, err, busy
  );

  modport slave (
    output req, req_read, req_siz, req_a, bmaster, dtack, berr,
    input  fcs, ds, doe, read_out, ack, err, busy
  );

endinterface

// File: rtl/zm_lane_decode.sv
// 68030 SIZ/A[1:0] to Zorro byte-lane strobe mask; ds[3] is offset 0.
module zm_lane_decode
  import zorro_master_cycle_pkg::*;
(
  input  logic [ZM_SIZ_W-1:0] i_siz,
  input  logic [ZM_A_W-1:0]   i_a,
  output logic [ZM_LANES-1:0] o_mask
);

  logic [2:0] w_n;
  logic [2:0] w_last;

  always_comb begin
    w_n = 3'd4;
    case (i_siz)
      SIZ_LONG:  w_n = 3'd4;
      SIZ_BYTE:  w_n = 3'd1;
      SIZ_WORD:  w_n = 3'd2;
      SIZ_3BYTE: w_n = 3'd3;
    endcase
    // Transfers that run past offset 3 are clipped by the loop bound.
    w_last = {1'b0, i_a} + w_n - 3'd1;
    o_mask = '0;
    for (int off = 0; off < ZM_LANES; off++) begin
      if ((3'(off) >= {1'b0, i_a}) && (3'(off) <= w_last)) begin
        o_mask[ZM_LANES-1-off] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zorro_master_cycle.sv
// Zorro III bus-master data-cycle sequencer for the NCR 53C710.
// ZORRO_MASTER_TIMEOUT_EN adds a DATA-state timeout that forces an error.
//   state      | meaning
//   ZM_IDLE    | waiting for req with bus granted
//   ZM_ADDR    | fcs asserted, address setup
//   ZM_DATA    | lane strobes out, waiting dtack/berr
//   ZM_TERM    | ack pulse, strobes released
//   ZM_ERR     | err pulse, strobes released
//   ZM_RECOVER | waiting for dtack and berr to negate
module zorro_master_cycle
  import zorro_master_cycle_pkg::*;
#(
  parameter int unsigned ADDR_SETUP = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  zorro_master_cycle_if.master bus
);

  if (ADDR_SETUP < 1 || ADDR_SETUP > 7) begin : g_bad_setup
    $error("ADDR_SETUP must be 1..7");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be 1..255");
  end

  zm_state_t           r_state;
  logic [ZM_SIZ_W-1:0] r_siz;
  logic [ZM_A_W-1:0]   r_a;
  logic [2:0]          r_setup_cnt;
  logic                r_fcs;
  logic [ZM_LANES-1:0] r_ds;
  logic                r_doe;
  logic                r_read_out;
  logic                r_ack;
  logic                r_err;
  logic [ZM_LANES-1:0] w_lane_mask;
  logic                w_to_expired;

  zm_lane_decode u_lane_decode (
    .i_siz  (r_siz),
    .i_a    (r_a),
    .o_mask (w_lane_mask)
  );

`ifdef ZORRO_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);
  logic [7:0] r_to_cnt;

  // Reloaded outside DATA so it is full on the first DATA cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_to_cnt <= '0;
    end else if (r_state != ZM_DATA) begin
      r_to_cnt <= TO_LOAD;
    end else if (r_to_cnt != 8'd0) begin
      r_to_cnt <= r_to_cnt - 8'd1;
    end
  end

  assign w_to_expired = (r_to_cnt == 8'd0);
`else
  assign w_to_expired = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ZM_IDLE;
      r_siz       <= SIZ_LONG;
      r_a         <= '0;
      r_setup_cnt <= '0;
      r_fcs       <= 1'b0;
      r_ds        <= '0;
      r_doe       <= 1'b0;
      r_read_out  <= 1'b1;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ZM_IDLE: begin
          if (bus.req && bus.bmaster) begin
            r_siz       <= bus.req_siz;
            r_a         <= bus.req_a;
            r_read_out  <= bus.req_read;
            r_setup_cnt <= 3'(ADDR_SETUP - 1);
            r_fcs       <= 1'b1;
            r_state     <= ZM_ADDR;
          end
        end
        ZM_ADDR: begin
          if (bus.berr || !bus.bmaster) begin
            r_err   <= 1'b1;
            r_fcs   <= 1'b0;
            r_state <= ZM_ERR;
          end else if (r_setup_cnt == 3'd0) begin
            r_ds    <= w_lane_mask;
            r_doe   <= !r_read_out;
            r_state <= ZM_DATA;
          end else begin
            r_setup_cnt <= r_setup_cnt - 3'd1;
          end
        end
        ZM_DATA: begin
          if (bus.berr || !bus.bmaster) begin
            r_err   <= 1'b1;
            r_fcs   <= 1'b0;
            r_ds    <= '0;
            r_doe   <= 1'b0;
            r_state <= ZM_ERR;
          end else if (bus.dtack) begin
            r_ack   <= 1'b1;
            r_fcs   <= 1'b0;
            r_ds    <= '0;
            r_doe   <= 1'b0;
            r_state <= ZM_TERM;
          end else if (w_to_expired) begin
            r_err   <= 1'b1;
            r_fcs   <= 1'b0;
            r_ds    <= '0;
            r_doe   <= 1'b0;
            r_state <= ZM_ERR;
          end
        end
        ZM_TERM, ZM_ERR: begin
          r_state <= ZM_RECOVER;
        end
        ZM_RECOVER: begin
          if (!bus.dtack && !bus.berr) begin
            r_read_out <= 1'b1;
            r_state    <= ZM_IDLE;
          end
        end
        default: begin
          r_state <= ZM_IDLE;
        end
      endcase
    end
  end

  assign bus.fcs      = r_fcs;
  assign bus.ds       = r_ds;
  assign bus.doe      = r_doe;
  assign bus.read_out = r_read_out;
  assign bus.ack      = r_ack;
  assign bus.err      = r_err;
  assign bus.busy     = (r_state != ZM_IDLE);

endmodule

// File: tb/tb_zorro_master_cycle.sv
// Directed bench for zorro_master_cycle (ADDR_SETUP=1, TIMEOUT=4).
module tb_zorro_master_cycle;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Output vector: {fcs, ds[3:0], doe, read_out, ack, err, busy}
  localparam logic [9:0] O_IDLE   = 10'b0_0000_0_1_0_0_0;
  localparam logic [9:0] O_ADDR_R = 10'b1_0000_0_1_0_0_1;
  localparam logic [9:0] O_DATA_R = 10'b1_1111_0_1_0_0_1;
  localparam logic [9:0] O_TERM_R = 10'b0_0000_0_1_1_0_1;
  localparam logic [9:0] O_RECV_R = 10'b0_0000_0_1_0_0_1;

  logic [3:0] lane_exp [16] = '{
    4'b1111, 4'b0111, 4'b0011, 4'b0001,
    4'b1000, 4'b0100, 4'b0010, 4'b0001,
    4'b1100, 4'b0110, 4'b0011, 4'b0001,
    4'b1110, 4'b0111, 4'b0011, 4'b0001
  };

  zorro_master_cycle_if zif ();

  zorro_master_cycle #(.ADDR_SETUP(1), .TIMEOUT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (zif)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] outs();
    return {zif.fcs, zif.ds, zif.doe, zif.read_out, zif.ack, zif.err, zif.busy};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    zif.req      = 1'b0;
    zif.req_read = 1'b1;
    zif.req_siz  = 2'b00;
    zif.req_a    = 2'b00;
    zif.bmaster  = 1'b1;
    zif.dtack    = 1'b0;
    zif.berr     = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    step();
    n_tests++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected %b", outs(), O_IDLE);
    end
    RST = 1'b0;
    step();
    n_tests++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL post_reset_outs: got %b expected %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_long_read();
    zif.req = 1'b1; zif.req_read = 1'b1; zif.req_siz = 2'b00; zif.req_a = 2'b00;
    step();
    n_tests++;
    if (outs() !== O_ADDR_R) begin
      n_fail++;
      $display("FAIL lr_addr: got %b expected %b", outs(), O_ADDR_R);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (outs() !== O_DATA_R) begin
        n_fail++;
        $display("FAIL lr_data%0d: got %b expected %b", k, outs(), O_DATA_R);
      end
    end
    zif.dtack = 1'b1;
    step();
    n_tests++;
    if (outs() !== O_TERM_R) begin
      n_fail++;
      $display("FAIL lr_term: got %b expected %b", outs(), O_TERM_R);
    end
    zif.req = 1'b0;
    step();
    n_tests++;
    if (outs() !== O_RECV_R) begin
      n_fail++;
      $display("FAIL lr_recover_hold: got %b expected %b", outs(), O_RECV_R);
    end
    zif.dtack = 1'b0;
    step();
    n_tests++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL lr_idle: got %b expected %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_lane_sweep();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] idx;
      idx = 4'(i);
      zif.req = 1'b1; zif.req_read = 1'b0;
      zif.req_siz = idx[3:2]; zif.req_a = idx[1:0];
      step();
      n_tests++;
      if (zif.doe !== 1'b0 || zif.read_out !== 1'b0 || zif.ds !== 4'b0000) begin
        n_fail++;
        $display("FAIL sweep_addr%0d: got doe=%b rd=%b ds=%b expected doe=0 rd=0 ds=0000",
                 i, zif.doe, zif.read_out, zif.ds);
      end
      step();
      n_tests++;
      if (zif.ds !== lane_exp[i] || zif.doe !== 1'b1 || zif.fcs !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_data%0d: got ds=%b doe=%b fcs=%b expected ds=%b doe=1 fcs=1",
                 i, zif.ds, zif.doe, zif.fcs, lane_exp[i]);
      end
      zif.dtack = 1'b1;
      step();
      n_tests++;
      if (zif.ack !== 1'b1 || zif.err !== 1'b0 || zif.doe !== 1'b0 || zif.ds !== 4'b0000) begin
        n_fail++;
        $display("FAIL sweep_term%0d: got ack=%b err=%b doe=%b ds=%b expected 1 0 0 0000",
                 i, zif.ack, zif.err, zif.doe, zif.ds);
      end
      zif.req = 1'b0; zif.dtack = 1'b0;
      step();
      step();
      n_tests++;
      if (outs() !== O_IDLE) begin
        n_fail++;
        $display("FAIL sweep_idle%0d: got %b expected %b", i, outs(), O_IDLE);
      end
    end
  endtask

  task automatic test_berr_dtack();
    zif.req = 1'b1; zif.req_read = 1'b0; zif.req_siz = 2'b00; zif.req_a = 2'b00;
    step();
    step();
    zif.berr = 1'b1; zif.dtack = 1'b1;
    step();
    n_tests++;
    if (zif.err !== 1'b1 || zif.ack !== 1'b0 || zif.fcs !== 1'b0 || zif.doe !== 1'b0) begin
      n_fail++;
      $display("FAIL be_err: got err=%b ack=%b fcs=%b doe=%b expected 1 0 0 0",
               zif.err, zif.ack, zif.fcs, zif.doe);
    end
    zif.req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++;
      if (outs() !== 10'b0_0000_0_0_0_0_1) begin
        n_fail++;
        $display("FAIL be_recover%0d: got %b expected %b", k, outs(), 10'b0_0000_0_0_0_0_1);
      end
    end
    zif.dtack = 1'b0;
    step();
    n_tests++;
    if (zif.busy !== 1'b1 || zif.ack !== 1'b0 || zif.err !== 1'b0) begin
      n_fail++;
      $display("FAIL be_berr_only: got busy=%b ack=%b err=%b expected 1 0 0",
               zif.busy, zif.ack, zif.err);
    end
    zif.berr = 1'b0;
    step();
    n_tests++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL be_idle: got %b expected %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_timeout();
    zif.req = 1'b1; zif.req_read = 1'b1; zif.req_siz = 2'b00; zif.req_a = 2'b00;
    step();
    step();
`ifdef ZORRO_MASTER_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (outs() !== O_DATA_R) begin
        n_fail++;
        $display("FAIL to_wait%0d: got %b expected %b", k, outs(), O_DATA_R);
      end
    end
    step();
    n_tests++;
    if (zif.err !== 1'b1 || zif.ack !== 1'b0 || zif.fcs !== 1'b0 || zif.ds !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_err: got err=%b ack=%b fcs=%b ds=%b expected 1 0 0 0000",
               zif.err, zif.ack, zif.fcs, zif.ds);
    end
    zif.req = 1'b0;
`else
    begin
      int errs;
      errs = 0;
      for (int k = 0; k < 300; k++) begin
        step();
        if (zif.err === 1'b1) errs++;
      end
      n_tests++;
      if (outs() !== O_DATA_R || errs != 0) begin
        n_fail++;
        $display("FAIL to_none: got %b errs=%0d expected %b errs=0", outs(), errs, O_DATA_R);
      end
    end
    zif.bmaster = 1'b0;
    step();
    n_tests++;
    if (zif.err !== 1'b1 || zif.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL to_grant_loss: got err=%b ack=%b expected 1 0", zif.err, zif.ack);
    end
    zif.req = 1'b0; zif.bmaster = 1'b1;
`endif
    step();
    step();
    n_tests++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL to_idle: got %b expected %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_grant_loss_addr();
    zif.req = 1'b1; zif.req_read = 1'b1; zif.req_siz = 2'b10; zif.req_a = 2'b00;
    step();
    zif.bmaster = 1'b0;
    step();
    n_tests++;
    if (zif.err !== 1'b1 || zif.ack !== 1'b0 || zif.fcs !== 1'b0 || zif.ds !== 4'b0000) begin
      n_fail++;
      $display("FAIL gl_err: got err=%b ack=%b fcs=%b ds=%b expected 1 0 0 0000",
               zif.err, zif.ack, zif.fcs, zif.ds);
    end
    zif.req = 1'b0; zif.bmaster = 1'b1;
    step();
    step();
    n_tests++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL gl_idle: got %b expected %b", outs(), O_IDLE);
    end
    zif.req = 1'b1; zif.req_read = 1'b0; zif.req_siz = 2'b01; zif.req_a = 2'b10;
    step();
    step();
    n_tests++;
    if (outs() !== 10'b1_0010_1_0_0_0_1) begin
      n_fail++;
      $display("FAIL gl_retry_data: got %b expected %b", outs(), 10'b1_0010_1_0_0_0_1);
    end
    zif.dtack = 1'b1;
    step();
    n_tests++;
    if (zif.ack !== 1'b1 || zif.err !== 1'b0) begin
      n_fail++;
      $display("FAIL gl_retry_ack: got ack=%b err=%b expected 1 0", zif.ack, zif.err);
    end
    zif.req = 1'b0; zif.dtack = 1'b0;
    step();
    step();
  endtask

  task automatic test_wait_grant();
    zif.req = 1'b1; zif.req_read = 1'b1; zif.req_siz = 2'b00; zif.req_a = 2'b00;
    zif.bmaster = 1'b0;
    step();
    step();
    n_tests++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL wg_hold: got %b expected %b", outs(), O_IDLE);
    end
    zif.bmaster = 1'b1;
    step();
    n_tests++;
    if (outs() !== O_ADDR_R) begin
      n_fail++;
      $display("FAIL wg_addr: got %b expected %b", outs(), O_ADDR_R);
    end
    step();
    zif.dtack = 1'b1;
    step();
    zif.req = 1'b0; zif.dtack = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    zif.req = 1'b1; zif.req_read = 1'b0; zif.req_siz = 2'b00; zif.req_a = 2'b00;
    step();
    step();
    RST = 1'b1;
    step();
    n_tests++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL rm_reset: got %b expected %b", outs(), O_IDLE);
    end
    RST = 1'b0; zif.req = 1'b0;
    step();
    n_tests++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL rm_after: got %b expected %b", outs(), O_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_long_read();
    test_lane_sweep();
    test_berr_dtack();
    test_timeout();
    test_grant_loss_addr();
    test_wait_grant();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
